aer_decoder: RTL and testbench

AER_DECODER -- requirements
Module: aer_decoder

---
 rtl/aer_pkg.sv | 15 +
 rtl/aer_fifo.sv | 46 ++++
 rtl/aer_decoder.sv | 110 +++++++++++
 tb/tb_aer_decoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// Shared constants and types for the address-event decoder and its input FIFO.
package aer_pkg;
  localparam int unsigned NEURON_ADR_DEF = 8;
  localparam int unsigned NEURON_NUM_DEF = 8;
  localparam int unsigned FIFO_DEPTH     = 8;
  localparam int unsigned FIFO_PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W     = FIFO_PTR_W + 1;

  localparam logic [NEURON_ADR_DEF:0] NULL_ADDR = '1;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;
endpackage

// File: rtl/aer_fifo.sv
// 8-entry in-order FIFO; a pushed entry becomes visible at the read port one cycle later.
module aer_fifo
  import aer_pkg::*;
#(
  parameter int unsigned WIDTH = NEURON_ADR_DEF + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);
  logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] r_wr;
  logic [FIFO_PTR_W-1:0] r_rd;
  logic [FIFO_CNT_W-1:0] r_count;
  logic                  w_push;
  logic                  w_pop;

  assign full     = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd];
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + FIFO_PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + FIFO_PTR_W'(1);
      r_count <= r_count + FIFO_CNT_W'(w_push) - FIFO_CNT_W'(w_pop);
    end
  end
endmodule

// File: rtl/aer_decoder.sv
// Collects address events per timestep into a spike vector; emits it after TICK once the queue drains.
module aer_decoder
  import aer_pkg::*;
#(
  parameter int unsigned NEURON_ADR = NEURON_ADR_DEF,
  parameter int unsigned NEURON_NUM = NEURON_NUM_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EV_VALID,
  input  logic [NEURON_ADR:0] EV_ADDR,
  output logic                EV_READY,
  input  logic                TICK,
  output logic [NEURON_NUM:0] SPIKES,
  output logic                EN_NEURON,
  output logic [7:0]          DROP_CNT,
  output logic                OVERRUN
);
  localparam int unsigned AW = NEURON_ADR + 1;
  localparam int unsigned NW = NEURON_NUM + 1;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [NW-1:0]         r_acc;
  logic [NW-1:0]         r_spikes;
  logic                  r_en;
  logic [7:0]            r_drop;
  logic                  r_ovr;
  logic                  w_full;
  logic                  w_empty;
  logic [FIFO_CNT_W-1:0] w_count;
  logic [AW-1:0]         w_pop_addr;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_in_range;
  logic [NW-1:0]         w_hit;
  logic                  w_emit;
  logic                  w_ovr_set;

  assign EV_READY   = !RST && (r_state == RUN) && !w_full;
  assign w_push     = EV_VALID && EV_READY;
  assign w_pop      = !w_empty;
  assign w_in_range = (32'(w_pop_addr) <= NEURON_NUM);
  assign w_hit      = NW'(1) << w_pop_addr;

  aer_fifo #(.WIDTH(AW)) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (w_push),
    .push_data (EV_ADDR),
    .pop       (w_pop),
    .pop_data  (w_pop_addr),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  a_count_consistent: assert property (@(posedge CLK) disable iff (RST)
    w_empty == (w_count == '0));

  always_ff @(posedge CLK) begin
    if (RST) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // DRAIN waits for the queue to empty; the emission and return to RUN share that edge.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      RUN: begin
        if (TICK) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (TICK) w_ovr_set = 1'b1;
        if (w_empty) begin
          w_emit      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc    <= '0;
      r_spikes <= '0;
      r_en     <= 1'b0;
      r_drop   <= '0;
      r_ovr    <= 1'b0;
    end else begin
      r_en <= w_emit;
      if (w_ovr_set) r_ovr <= 1'b1;
      if (w_emit) begin
        r_spikes <= r_acc;
        r_acc    <= '0;
      end else if (w_pop && w_in_range) begin
        r_acc <= r_acc | w_hit;
      end
      if (w_pop && !w_in_range && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  assign SPIKES    = r_spikes;
  assign EN_NEURON = r_en;
  assign DROP_CNT  = r_drop;
  assign OVERRUN   = r_ovr;
endmodule

// File: tb/tb_aer_decoder.sv
// Randomized and directed bench for aer_decoder against a queue-based timestep model.
module tb_aer_decoder;
  import aer_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EV_VALID = 1'b0;
  logic [8:0] EV_ADDR = '0;
  logic       EV_READY;
  logic       TICK = 1'b0;
  logic [8:0] SPIKES;
  logic       EN_NEURON;
  logic [7:0] DROP_CNT;
  logic       OVERRUN;

  int n_checks = 0;
  int n_err    = 0;

  aer_decoder #(.NEURON_ADR(8), .NEURON_NUM(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EV_VALID  (EV_VALID),
    .EV_ADDR   (EV_ADDR),
    .EV_READY  (EV_READY),
    .TICK      (TICK),
    .SPIKES    (SPIKES),
    .EN_NEURON (EN_NEURON),
    .DROP_CNT  (DROP_CNT),
    .OVERRUN   (OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending addresses, accumulator set, and a draining flag.
  int         q[$];
  bit         m_valid = 1'b0;
  bit         m_drain;
  logic [8:0] m_acc;
  logic [8:0] m_spikes;
  bit         m_en;
  int         m_drop;
  bit         m_ovr;

  always @(negedge CLK) begin : model
    bit exp_ready;
    bit had;
    bit emit;
    int a;
    exp_ready = !RST && !m_drain && (q.size() < 8);
    if (RST) exp_ready = 1'b0;
    chk("ev_ready", 32'(EV_READY), 32'(exp_ready));
    if (m_valid) begin
      chk("spikes",    32'(SPIKES),    32'(m_spikes));
      chk("en_neuron", 32'(EN_NEURON), 32'(m_en));
      chk("drop_cnt",  32'(DROP_CNT),  32'(m_drop));
      chk("overrun",   32'(OVERRUN),   32'(m_ovr));
    end
    if (RST) begin
      q.delete();
      m_drain = 0; m_acc = '0; m_spikes = '0; m_en = 0; m_drop = 0; m_ovr = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      had  = (q.size() > 0);
      emit = m_drain && !had;
      if (m_drain && TICK) m_ovr = 1;
      if (had) begin
        a = q.pop_front();
        if (a <= 8) m_acc[a] = 1'b1;
        else if (m_drop < 255) m_drop++;
      end
      if (EV_VALID && exp_ready) q.push_back(int'(EV_ADDR));
      m_en = emit;
      if (emit) begin
        m_spikes = m_acc;
        m_acc    = '0;
        m_drain  = 0;
      end else if (!m_drain && TICK) begin
        m_drain = 1;
      end
    end
  end

  task automatic drive(input bit v, input logic [8:0] a, input bit t, input bit r);
    @(posedge CLK);
    #1;
    EV_VALID = v;
    EV_ADDR  = a;
    TICK     = t;
    RST      = r;
  endtask

  task automatic do_reset();
    drive(0, '0, 0, 1);
    drive(0, '0, 0, 1);
    drive(0, '0, 0, 0);
  endtask

  task automatic wait_emit(input string name, input logic [8:0] exp, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      drive(0, '0, 0, 0);
      @(negedge CLK);
      if (EN_NEURON) begin
        chk(name, 32'(SPIKES), 32'(exp));
        lat = i;
        return;
      end
    end
    n_checks++;
    n_err++;
    $display("FAIL %s: got no EN_NEURON pulse expected one within 40 cycles", name);
  endtask

  initial begin : stim
    int lat;
    int pulses;

    do_reset();
    @(negedge CLK);
    chk("rst_spikes", 32'(SPIKES),    32'd0);
    chk("rst_en",     32'(EN_NEURON), 32'd0);
    chk("rst_drop",   32'(DROP_CNT),  32'd0);
    chk("rst_ovr",    32'(OVERRUN),   32'd0);
    chk("rst_ready",  32'(EV_READY),  32'd1);

    // Single event: accepted cycle 0, TICK cycle 5, pulse cycle 7.
    drive(1, 9'd3, 0, 0);
    repeat (4) drive(0, '0, 0, 0);
    drive(0, '0, 1, 0);
    wait_emit("single_spikes", 9'b000001000, lat);
    chk("single_latency", 32'(lat), 32'd1);

    do_reset();
    drive(1, 9'd0, 0, 0);
    drive(1, 9'd8, 0, 0);
    drive(1, 9'd0, 0, 0);
    drive(1, 9'd4, 0, 0);
    drive(0, '0, 1, 0);
    wait_emit("multi_spikes", 9'b100010001, lat);
    chk("multi_drop", 32'(DROP_CNT), 32'd0);

    do_reset();
    drive(1, 9'h1FF, 0, 0);
    drive(1, 9'd9, 0, 0);
    drive(1, 9'd2, 0, 0);
    drive(0, '0, 1, 0);
    wait_emit("drop_spikes", 9'b000000100, lat);
    chk("drop_cnt2", 32'(DROP_CNT), 32'd2);

    // Nine back-to-back events, TICK with the last; an offer during DRAIN must be refused.
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, 9'(i), 0, 0);
    drive(1, 9'd8, 1, 0);
    drive(1, 9'd5, 0, 0);
    @(negedge CLK);
    chk("drain_ready", 32'(EV_READY), 32'd0);
    wait_emit("full_spikes", 9'h1FF, lat);
    drive(0, '0, 1, 0);
    wait_emit("full_nolost", 9'h000, lat);

    do_reset();
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 0);
    wait_emit("ovr_spikes", 9'h000, lat);
    chk("ovr_flag", 32'(OVERRUN), 32'd1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, '0, 0, 0);
      @(negedge CLK);
      if (EN_NEURON) pulses++;
    end
    chk("ovr_single_pulse", 32'(pulses), 32'd0);
    chk("ovr_sticky", 32'(OVERRUN), 32'd1);

    // Reset while draining with an entry queued and a prior drop counted.
    do_reset();
    drive(1, NULL_ADDR, 0, 0);
    drive(1, 9'd2, 1, 0);
    drive(0, '0, 0, 1);
    drive(0, '0, 0, 0);
    @(negedge CLK);
    chk("rstd_drop",  32'(DROP_CNT),  32'd0);
    chk("rstd_en",    32'(EN_NEURON), 32'd0);
    chk("rstd_ready", 32'(EV_READY),  32'd1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, '0, 0, 0);
      @(negedge CLK);
      if (EN_NEURON) pulses++;
    end
    chk("rstd_no_pulse", 32'(pulses), 32'd0);
    drive(0, '0, 1, 0);
    wait_emit("rstd_spikes", 9'h000, lat);

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 270; i++) drive(1, NULL_ADDR, 0, 0);
    repeat (3) drive(0, '0, 0, 0);
    @(negedge CLK);
    chk("drop_sat", 32'(DROP_CNT), 32'd255);

    // Random traffic with occasional resets; the model checks every cycle.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [8:0] a;
      if ($urandom_range(0, 9) < 8) a = 9'($urandom_range(0, 8));
      else if ($urandom_range(0, 1) == 0) a = NULL_ADDR;
      else a = 9'($urandom_range(9, 510));
      drive($urandom_range(0, 9) < 7, a, $urandom_range(0, 11) == 0,
            $urandom_range(0, 299) == 0);
    end
    repeat (20) drive(0, '0, 0, 0);
    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
